// File: rtl/exotiny_qspi_arb.sv
// Arbiter/sequencer between the core's fetch and data ports and the shared QSPI controller.
// Define EXOTINY_QSPI_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module exotiny_qspi_arb #(
  parameter int ADDR_W = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  input  logic [ADDR_W-1:0] instr_adr_i,
  output logic              instr_ack_o,
  output logic [31:0]       instr_rdat_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_adr_i,
  input  logic [31:0]       data_wdat_i,
  output logic              data_ack_o,
  output logic              data_err_o,
  output logic [31:0]       data_rdat_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-2:0] mem_adr_o,
  output logic [31:0]       mem_wdat_o,
  output logic              mem_sel_ram_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdat_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ERR} state_t;

  state_t state, state_nxt;
  logic   pick_data;
  logic   data_rom_wr;

  // Writes to ROM are answered with an error and never reach the controller.
  assign data_rom_wr = data_we_i & ~data_adr_i[ADDR_W-1];

`ifdef EXOTINY_QSPI_ARB_RR_EN
  logic last_data;

  assign pick_data = data_req_i & (~instr_req_i | ~last_data);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_data <= 1'b0;
    end else if (state == IDLE && state_nxt != IDLE) begin
      last_data <= pick_data;
    end
  end
`else
  assign pick_data = data_req_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_data) begin
          state_nxt = data_rom_wr ? ERR : GNT_D;
        end else if (instr_req_i) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack_i) begin
          state_nxt = IDLE;
        end
      end
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controller-side request: captured on the IDLE exit edge, released on the controller ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_be_o      <= 4'h0;
      mem_adr_o     <= '0;
      mem_wdat_o    <= 32'h0;
      mem_sel_ram_o <= 1'b0;
    end else if (state == IDLE) begin
      if (state_nxt == GNT_D) begin
        mem_req_o     <= 1'b1;
        mem_we_o      <= data_we_i;
        mem_be_o      <= data_be_i;
        mem_adr_o     <= data_adr_i[ADDR_W-2:0];
        mem_wdat_o    <= data_wdat_i;
        mem_sel_ram_o <= data_adr_i[ADDR_W-1];
      end else if (state_nxt == GNT_I) begin
        mem_req_o     <= 1'b1;
        mem_we_o      <= 1'b0;
        mem_be_o      <= 4'hF;
        mem_adr_o     <= instr_adr_i[ADDR_W-2:0];
        mem_wdat_o    <= 32'h0;
        mem_sel_ram_o <= instr_adr_i[ADDR_W-1];
      end
    end else if ((state == GNT_I || state == GNT_D) && mem_ack_i) begin
      mem_req_o <= 1'b0;
    end
  end

  assign instr_ack_o  = (state == GNT_I) & mem_ack_i;
  assign data_ack_o   = ((state == GNT_D) & mem_ack_i) | (state == ERR);
  assign data_err_o   = (state == ERR);
  // Read data is gated by the ack so every output is quiet while idle or in reset.
  assign instr_rdat_o = instr_ack_o ? mem_rdat_i : 32'h0;
  assign data_rdat_o  = data_ack_o ? mem_rdat_i : 32'h0;
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_exotiny_qspi_arb.sv
// Randomized and directed bench for exotiny_qspi_arb against a transaction-level reference model.
module tb_exotiny_qspi_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mack = 1'b0;
  logic [23:0] iadr = '0, dadr = '0;
  logic [3:0]  dbe = '0;
  logic [31:0] dwdat = '0, mrdat = '0;
  logic        instr_ack, data_ack, data_err, mem_req, mem_we, mem_sel_ram, busy;
  logic [31:0] instr_rdat, data_rdat, mem_wdat;
  logic [3:0]  mem_be;
  logic [22:0] mem_adr;

  int checks = 0;
  int failures = 0;

  exotiny_qspi_arb #(.ADDR_W(24)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(ireq), .instr_adr_i(iadr), .instr_ack_o(instr_ack), .instr_rdat_o(instr_rdat),
    .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe), .data_adr_i(dadr), .data_wdat_i(dwdat),
    .data_ack_o(data_ack), .data_err_o(data_err), .data_rdat_o(data_rdat),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_adr_o(mem_adr),
    .mem_wdat_o(mem_wdat), .mem_sel_ram_o(mem_sel_ram), .mem_ack_i(mack), .mem_rdat_i(mrdat),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who currently owns the controller (0 none, 1 fetch, 2 data, 3 ROM-write error)
  int          m_owner = 0;
  bit          m_last_data = 1'b0;
  logic [22:0] cap_adr;
  logic        cap_sel, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdat;
  bit          exp_iack, exp_dack, exp_err;

  function automatic int winner(bit i, bit d, bit last_d);
    if (!i && !d) return 0;
    if (i && !d) return 1;
    if (d && !i) return 2;
`ifdef EXOTINY_QSPI_ARB_RR_EN
    return last_d ? 1 : 2;
`else
    return 2;
`endif
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_last_data = 1'b0;
  endtask

  task automatic model_step();
    int w;
    case (m_owner)
      0: begin
        w = winner(ireq, dreq, m_last_data);
        if (w == 1) begin
          cap_adr = iadr[22:0]; cap_sel = iadr[23]; cap_we = 1'b0; cap_be = 4'hF;
        end else if (w == 2) begin
          cap_adr = dadr[22:0]; cap_sel = dadr[23]; cap_we = dwe; cap_be = dbe; cap_wdat = dwdat;
          if (dwe && !dadr[23]) w = 3;
        end
        if (w != 0) m_last_data = (w != 1);
        m_owner = w;
      end
      1, 2: if (mack) m_owner = 0;
      default: m_owner = 0;
    endcase
  endtask

  task automatic check_outputs();
    exp_iack = (m_owner == 1) && mack;
    exp_dack = ((m_owner == 2) && mack) || (m_owner == 3);
    exp_err  = (m_owner == 3);
    check("busy", busy, m_owner != 0);
    check("mem_req", mem_req, m_owner == 1 || m_owner == 2);
    check("instr_ack", instr_ack, exp_iack);
    check("data_ack", data_ack, exp_dack);
    check("data_err", data_err, exp_err);
    if (m_owner == 1 || m_owner == 2) begin
      check("mem_adr", mem_adr, cap_adr);
      check("mem_sel", mem_sel_ram, cap_sel);
      check("mem_we", mem_we, cap_we);
      check("mem_be", mem_be, cap_be);
    end
    if (m_owner == 2) check("mem_wdat", mem_wdat, cap_wdat);
    if (exp_iack) check("instr_rdat", instr_rdat, mrdat);
    if (exp_dack && m_owner == 2) check("data_rdat", data_rdat, mrdat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_req"}, mem_req, 1'b0);
    check({tag, "_acks"}, {instr_ack, data_ack, data_err}, 3'b000);
    check({tag, "_mem"}, {mem_we, mem_be, mem_adr, mem_sel_ram, mem_wdat}, '0);
    check({tag, "_rdat"}, {instr_rdat, data_rdat}, '0);
  endtask

  task automatic sample();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("reset");
    advance();
    advance();
    rst = 1'b0;
  endtask

  int ord[6];
  int n, idle_cnt;

  initial begin
    // Reset with a RAM read already pending
    dreq = 1'b1; dwe = 1'b0; dbe = 4'hF; dadr = 24'h800040; mrdat = 32'hA5A5A5A5;
    do_reset();
    sample();
    check("rst_rel_idle", mem_req, 1'b0);
    advance();
    sample();
    check("rst_rel_req", mem_req, 1'b1);
    check("rst_rel_sel", mem_sel_ram, 1'b1);
    advance();
    mack = 1'b1;
    cyc();
    mack = 1'b0; dreq = 1'b0;
    cyc();

    // Fetch from ROM, controller answers 10 cycles later
    ireq = 1'b1; iadr = 24'h000100;
    cyc();
    repeat (10) cyc();
    mack = 1'b1; mrdat = 32'hDEADBEEF;
    sample();
    check("fetch_adr", mem_adr, 23'h000100);
    check("fetch_sel", mem_sel_ram, 1'b0);
    check("fetch_be", mem_be, 4'hF);
    check("fetch_ack", instr_ack, 1'b1);
    check("fetch_rdat", instr_rdat, 32'hDEADBEEF);
    advance();
    mack = 1'b0; ireq = 1'b0;
    cyc();

    // Write to ROM is rejected without a controller request
    dreq = 1'b1; dwe = 1'b1; dbe = 4'h3; dadr = 24'h000010; dwdat = 32'h0BADF00D;
    cyc();
    sample();
    check("romwr_ack", {data_ack, data_err}, 2'b11);
    check("romwr_noreq", mem_req, 1'b0);
    advance();
    dreq = 1'b0;
    sample();
    check("romwr_once", {data_ack, data_err, mem_req}, 3'b000);
    advance();

    // Write to RAM
    dreq = 1'b1; dwe = 1'b1; dbe = 4'h1; dadr = 24'h800020; dwdat = 32'h12345678;
    cyc();
    mack = 1'b1; mrdat = 32'h0;
    sample();
    check("ramwr_sel", mem_sel_ram, 1'b1);
    check("ramwr_adr", mem_adr, 23'h000020);
    check("ramwr_we", mem_we, 1'b1);
    check("ramwr_ack_err", {data_ack, data_err}, 2'b10);
    advance();
    mack = 1'b0; dreq = 1'b0;
    cyc();

    // Both requesters held for six transfers; the controller acks at once
    do_reset();
    ireq = 1'b1; iadr = 24'h000200;
    dreq = 1'b1; dwe = 1'b0; dbe = 4'hF; dadr = 24'h800300;
    n = 0; idle_cnt = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      mack = (m_owner == 1 || m_owner == 2);
      mrdat = $urandom;
      sample();
      if (!busy) idle_cnt++;
      if (instr_ack) begin ord[n] = 1; n++; end
      else if (data_ack) begin ord[n] = 2; n++; end
      advance();
    end
    mack = 1'b0; ireq = 1'b0; dreq = 1'b0;
    check("both_count", n, 6);
    check("both_idle", idle_cnt, 6);
    for (int k = 0; k < 6; k++) begin
`ifdef EXOTINY_QSPI_ARB_RR_EN
      check("both_order", ord[k], (k % 2 == 0) ? 2 : 1);
`else
      check("both_order", ord[k], 2);
`endif
    end
    cyc();

    // Asynchronous reset while a data grant is outstanding
    dreq = 1'b1; dwe = 1'b0; dbe = 4'hF; dadr = 24'h800400;
    cyc();
    sample();
    check("midrst_req", mem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req_drop", mem_req, 1'b0);
    check("midrst_busy_drop", busy, 1'b0);
    model_reset();
    dreq = 1'b0;
    advance();
    rst = 1'b0;
    mack = 1'b1;
    sample();
    check("midrst_late_ack", {instr_ack, data_ack}, 2'b00);
    advance();
    mack = 1'b0;

    // Randomized traffic with spurious controller acks while idle
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      sample();
      advance();
      if (exp_iack) ireq = 1'b0;
      if (exp_dack) dreq = 1'b0;
      if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1'b1; iadr = 24'($urandom);
      end
      if (!dreq && $urandom_range(0, 2) == 0) begin
        dreq = 1'b1; dwe = 1'($urandom); dbe = 4'($urandom);
        dadr = 24'($urandom); dwdat = $urandom;
      end
      mack = (m_owner == 1 || m_owner == 2) ? ($urandom_range(0, 2) == 0)
                                            : ($urandom_range(0, 7) == 0);
      mrdat = $urandom;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
